nios_v1_mem_copy_master: RTL and testbench
==========================================

NIOS_V1_MEM_COPY_MASTER -- requirements
Module: nios_v1_mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, Avalon byte-address width (covers 5120-word on-chip memory).
REQ-002 SHALL have parameter LEN_W, default 13, word-count width.
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  copy request, sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  terminate the active copy.
REQ-007 SHALL have port src_addr  in  ADDR_W  source byte address.
REQ-008 SHALL have port dst_addr  in  ADDR_W  destination byte address.
REQ-009 SHALL have port length  in  LEN_W  number of 32-bit words.
REQ-010 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port error  out  1  valid with done; high on zero length, misalignment or abort.
REQ-013 SHALL have ports avm_address (out, ADDR_W), avm_read (out, 1), avm_write (out, 1), avm_byteenable (out, 4), avm_writedata (out, 32): Avalon-MM master command.
REQ-014 SHALL have ports avm_readdata (in, 32), avm_waitrequest (in, 1), avm_readdatavalid (in, 1): Avalon-MM master response.

Function
REQ-015 SHALL implement states IDLE, RD, RD_WAIT, WR, DONE.
REQ-016 IDLE with start=1 SHALL latch src/dst/length; if length=0 or src_addr[1:0]/dst_addr[1:0] nonzero, go DONE with error=1 and no bus traffic; else go RD.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 RD SHALL drive avm_read=1, avm_address=src pointer; it SHALL hold all command outputs stable while avm_waitrequest=1 and go RD_WAIT on the first cycle with waitrequest=0.
REQ-019 RD_WAIT SHALL keep avm_read=0, capture avm_readdata into a 32-bit buffer on avm_readdatavalid=1, then go WR; it SHALL wait indefinitely otherwise.
REQ-020 WR SHALL drive avm_write=1, avm_address=dst pointer, avm_writedata=buffer, avm_byteenable=4'hF, held stable under waitrequest.
REQ-021 On WR accept (waitrequest=0): remaining decrements, both pointers advance by 4 modulo 2^ADDR_W (wrap to 0, no error), next state is DONE if remaining reaches 0, else RD.
REQ-022 DONE SHALL assert done for exactly one cycle, with busy=0 in that cycle, then return to IDLE.
REQ-023 avm_read and avm_write SHALL never be high together; avm_byteenable SHALL be 4'hF whenever either is high.
REQ-024 With zero waitrequest and read latency 1: start sampled at edge k, state RD from cycle k+1, done high in cycle k+1+3N; throughput 1 word per 3 cycles.
REQ-025 abort=1 in RD or WR SHALL wait for the current command to be accepted, never dropping it under waitrequest; abort in RD_WAIT SHALL wait for readdatavalid and discard the data; in each case the next state is DONE with error=1 and no further commands issue.
REQ-026 abort in IDLE or DONE SHALL be ignored; abort and start together in IDLE SHALL start the copy normally.
REQ-027 Overlapping regions SHALL be copied strictly ascending, word by word, with no overlap correction.
REQ-028 avm_readdatavalid outside RD_WAIT SHALL be ignored.

Reset
REQ-029 Asserting reset_n low, at any point including mid-transfer, SHALL immediately force IDLE with busy, done, error, avm_read and avm_write at 0; avm_address, avm_writedata, pointers, remaining and buffer at 0; avm_byteenable at 4'h0.

Structure
REQ-030 Package nios_v1_mem_copy_pkg SHALL hold the state enum, default ADDR_W/LEN_W constants and BE_ALL=4'hF.
REQ-031 SHALL be a single module with one FSM plus pointer/count registers and no sub-module.

Verification
REQ-032 src=0x0000, dst=0x1000, length=4, zero-wait 1-cycle-latency slave model -> dst words equal src words; done in cycle k+13; error=0.
REQ-033 length=0, or src=0x0002 -> done one cycle after start, error=1, no avm_read/avm_write observed.
REQ-034 Random 0-5 cycle waitrequest on reads and writes, length=8 -> address, data and command held stable under every waitrequest; data copied correctly.
REQ-035 abort pulsed in RD_WAIT of word 2 (length=5) -> no further writes; done with error=1; exactly 1 word written.
REQ-036 dst=0x7FFC, length=2 -> second write at address 0x0000.
REQ-037 reset_n low while in WR with waitrequest=1 -> avm_write=0 and busy=0 immediately (asynchronously); following start runs normally.

Source files
------------

// File: rtl/nios_v1_mem_copy_pkg.sv
// ----------------------------------------------------------------------------
// nios_v1_mem_copy_pkg
// Shared definitions for the word-by-word Avalon-MM copy master:
//   - default address / length widths
//   - the all-bytes byte-enable constant
//   - the copy FSM state encoding
// ----------------------------------------------------------------------------
package nios_v1_mem_copy_pkg;

    localparam int ADDR_W_DEF = 15;       // byte address, 5120-word on-chip RAM
    localparam int LEN_W_DEF  = 13;       // word count

    localparam logic [3:0] BE_ALL = 4'hF;  // full 32-bit word lanes

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/nios_v1_mem_copy_master.sv
// ----------------------------------------------------------------------------
// nios_v1_mem_copy_master
// Copies `length` 32-bit words from src_addr to dst_addr over one Avalon-MM
// master port, strictly ascending, one read then one write per word.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 copy request (sampled in IDLE only)
//   abort                 terminate the active copy after the in-flight command
//   src_addr, dst_addr    word-aligned byte addresses
//   length                number of words (0 is an error)
//   busy                  high while RD / RD_WAIT / WR
//   done                  one-cycle completion pulse
//   error                 qualified by done: zero length, misalignment or abort
//   avm_*                 Avalon-MM master command / response
// ----------------------------------------------------------------------------
module nios_v1_mem_copy_master
    import nios_v1_mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       buf_q, buf_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic              abort_now;

    // An abort pulse is remembered until the in-flight command or read
    // response has completed; the copy then terminates instead of continuing.
    assign abort_now = abort | abort_q;

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first so
        // no branch leaves one unassigned, which would infer a latch.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        err_d   = err_q;
        abort_d = abort_q;

        case (state_q)
            ST_IDLE: begin
                // abort is deliberately ignored here, even alongside start
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = length;
                    abort_d = 1'b0;
                    if (length == '0 || src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RD;
                    end
                end
            end

            ST_RD: begin
                abort_d = abort_now;
                if (!avm_waitrequest) begin
                    if (abort_now) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end

            ST_RD_WAIT: begin
                abort_d = abort_now;
                if (avm_readdatavalid) begin
                    if (abort_now) begin
                        // data of an aborted copy is dropped, buffer untouched
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        buf_d   = avm_readdata;
                        state_d = ST_WR;
                    end
                end
            end

            ST_WR: begin
                abort_d = abort_now;
                if (!avm_waitrequest) begin
                    rem_d = rem_q - LEN_W'(1);
                    // pointers wrap modulo 2^ADDR_W by plain overflow
                    src_d = src_q + ADDR_W'(4);
                    dst_d = dst_q + ADDR_W'(4);
                    if (abort_now) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end

            ST_DONE: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Command outputs decode purely from registered state, so they stay
    // stable for as long as waitrequest holds the FSM in RD or WR.
    always_comb begin
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_byteenable = 4'h0;
        if (state_q == ST_RD) begin
            avm_read       = 1'b1;
            avm_address    = src_q;
            avm_byteenable = BE_ALL;
        end else if (state_q == ST_WR) begin
            avm_write      = 1'b1;
            avm_address    = dst_q;
            avm_byteenable = BE_ALL;
        end
    end

    assign avm_writedata = buf_q;
    assign busy          = (state_q == ST_RD) || (state_q == ST_RD_WAIT) || (state_q == ST_WR);
    assign done          = (state_q == ST_DONE);
    assign error         = done & err_q;

endmodule

// File: tb/tb_nios_v1_mem_copy_master.sv
// ----------------------------------------------------------------------------
// tb_nios_v1_mem_copy_master
// Directed bench for the copy master: an Avalon slave model (read latency 1,
// optional random or forced waitrequest) backed by a word array, plus a
// driver issuing copy jobs with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_nios_v1_mem_copy_master;

    localparam int ADDR_W = 15;
    localparam int LEN_W  = 13;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read, avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata = '0;
    logic              avm_waitrequest = 1'b0;
    logic              avm_readdatavalid = 1'b0;

    nios_v1_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_byteenable   (avm_byteenable),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // ------------------------------------------------------------------
    // Slave model: everything happens on the falling edge, so waitrequest
    // and readdatavalid are settled half a cycle before the DUT samples.
    // ------------------------------------------------------------------
    logic [31:0]       mem [0:8191];
    bit                rand_wait = 1'b0;
    bit                hold_wr   = 1'b0;
    int                wcnt  = 0;
    int                n_rd  = 0;
    int                n_wr  = 0;
    int                n_cmd = 0;
    logic [ADDR_W-1:0] wr_log [0:15];
    bit                pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr = '0;
    bit                prev_stall = 1'b0;
    logic [52:0]       prev_cmd = '0;
    logic [52:0]       cur_cmd;

    task automatic init_mem();
        for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    endtask

    initial begin : slave
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (!reset_n) begin
                pend            = 1'b0;
                prev_stall      = 1'b0;
                avm_waitrequest = 1'b0;
                wcnt            = 0;
            end else begin
                if (pend) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem[pend_addr[14:2]];
                    pend              = 1'b0;
                end
                cur_cmd = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
                if (prev_stall) check("stall_hold", 64'(cur_cmd), 64'(prev_cmd));
                if (avm_read || avm_write) begin
                    n_cmd++;
                    check("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
                    check("byteenable", 64'(avm_byteenable), 64'hF);
                    if (hold_wr && avm_write) begin
                        avm_waitrequest = 1'b1;
                    end else if (wcnt > 0) begin
                        avm_waitrequest = 1'b1;
                        wcnt--;
                    end else begin
                        avm_waitrequest = 1'b0;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
                prev_stall = (avm_read || avm_write) && avm_waitrequest;
                prev_cmd   = cur_cmd;
                if ((avm_read || avm_write) && !avm_waitrequest)
                    wcnt = rand_wait ? int'($urandom_range(0, 5)) : 0;
                if (avm_read && !avm_waitrequest) begin
                    pend      = 1'b1;
                    pend_addr = avm_address;
                    n_rd++;
                end
                if (avm_write && !avm_waitrequest) begin
                    mem[avm_address[14:2]] = avm_writedata;
                    if (n_wr < 16) wr_log[n_wr] = avm_address;
                    n_wr++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver. Inputs change 1 time unit after the falling edge. The start
    // edge is k; the first falling edge after it lies in cycle k+1, so the
    // cycle count returned equals the offset of done from k.
    // ------------------------------------------------------------------
    task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [LEN_W-1:0] len, input bit with_abort,
                            output int cyc, output bit err_seen, output bit timeout);
        @(negedge clk); #1;
        src_addr = s;
        dst_addr = d;
        length   = len;
        start    = 1'b1;
        abort    = with_abort;
        n_rd = 0; n_wr = 0; n_cmd = 0;
        cyc = 0; err_seen = 1'b0; timeout = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            cyc++;
            if (done) begin
                err_seen = error;
                timeout  = 1'b0;
                break;
            end
        end
    endtask

    int cyc;
    bit err_seen, timeout, aborted;

    initial begin
        // reset state
        #1;
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_rdwr",  64'({avm_read, avm_write}), 64'd0);
        check("rst_addr",  64'(avm_address), 64'd0);
        check("rst_be",    64'(avm_byteenable), 64'd0);
        check("rst_wdata", 64'(avm_writedata), 64'd0);
        init_mem();
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // basic 4-word copy, abort raised together with start (ignored)
        run_copy(15'h0000, 15'h1000, 13'd4, 1'b1, cyc, err_seen, timeout);
        check("t1_timeout", 64'(timeout), 64'd0);
        check("t1_latency", 64'(cyc), 64'd13);
        check("t1_error",   64'(err_seen), 64'd0);
        check("t1_busy",    64'(busy), 64'd0);
        check("t1_nwr",     64'(n_wr), 64'd4);
        for (int j = 0; j < 4; j++) check($sformatf("t1_word%0d", j), 64'(mem[32'h400 + j]), 64'(pat(j)));
        check("t1_beyond",  64'(mem[32'h404]), 64'(pat(32'h404)));
        @(negedge clk); #1;
        check("t1_done_1cyc", 64'(done), 64'd0);

        // zero length and misaligned requests
        run_copy(15'h0000, 15'h1000, 13'd0, 1'b0, cyc, err_seen, timeout);
        check("t2_timeout", 64'(timeout), 64'd0);
        check("t2_latency", 64'(cyc), 64'd1);
        check("t2_error",   64'(err_seen), 64'd1);
        check("t2_nocmd",   64'(n_cmd), 64'd0);
        run_copy(15'h0002, 15'h1000, 13'd3, 1'b0, cyc, err_seen, timeout);
        check("t3_latency", 64'(cyc), 64'd1);
        check("t3_error",   64'(err_seen), 64'd1);
        check("t3_nocmd",   64'(n_cmd), 64'd0);
        run_copy(15'h0000, 15'h1001, 13'd3, 1'b0, cyc, err_seen, timeout);
        check("t3b_error",  64'(err_seen), 64'd1);
        check("t3b_nocmd",  64'(n_cmd), 64'd0);

        // random waitrequest on both reads and writes
        init_mem();
        rand_wait = 1'b1;
        run_copy(15'h0200, 15'h2000, 13'd8, 1'b0, cyc, err_seen, timeout);
        rand_wait = 1'b0;
        check("t4_timeout", 64'(timeout), 64'd0);
        check("t4_error",   64'(err_seen), 64'd0);
        check("t4_nwr",     64'(n_wr), 64'd8);
        for (int j = 0; j < 8; j++) check($sformatf("t4_word%0d", j), 64'(mem[32'h800 + j]), 64'(pat(32'h80 + j)));

        // abort during RD_WAIT of the second word
        init_mem();
        @(negedge clk); #1;
        src_addr = 15'h0300; dst_addr = 15'h3000; length = 13'd5; start = 1'b1;
        n_rd = 0; n_wr = 0; n_cmd = 0;
        aborted = 1'b0; err_seen = 1'b0; timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                err_seen = error;
                timeout  = 1'b0;
                break;
            end
            if (!aborted && n_rd == 2 && busy && !avm_read && !avm_write) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
        end
        check("t5_aborted", 64'(aborted), 64'd1);
        check("t5_timeout", 64'(timeout), 64'd0);
        check("t5_error",   64'(err_seen), 64'd1);
        check("t5_nwr",     64'(n_wr), 64'd1);
        check("t5_nrd",     64'(n_rd), 64'd2);
        check("t5_word0",   64'(mem[32'hC00]), 64'(pat(32'hC0)));
        check("t5_word1",   64'(mem[32'hC01]), 64'(pat(32'hC01)));

        // destination pointer wraps to 0
        init_mem();
        run_copy(15'h0100, 15'h7FFC, 13'd2, 1'b0, cyc, err_seen, timeout);
        check("t6_latency", 64'(cyc), 64'd7);
        check("t6_error",   64'(err_seen), 64'd0);
        check("t6_addr0",   64'(wr_log[0]), 64'h7FFC);
        check("t6_addr1",   64'(wr_log[1]), 64'h0000);
        check("t6_top",     64'(mem[32'h1FFF]), 64'(pat(32'h40)));
        check("t6_wrapped", 64'(mem[0]), 64'(pat(32'h41)));

        // asynchronous reset while a write is stalled
        init_mem();
        hold_wr = 1'b1;
        @(negedge clk); #1;
        src_addr = 15'h0400; dst_addr = 15'h4000; length = 13'd2; start = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (avm_write) begin
                timeout = 1'b0;
                break;
            end
        end
        check("t7_reach_wr", 64'(timeout), 64'd0);
        @(negedge clk); #1;
        check("t7_stalled", 64'(avm_write), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t7_write_off", 64'(avm_write), 64'd0);
        check("t7_busy_off",  64'(busy), 64'd0);
        check("t7_addr_zero", 64'(avm_address), 64'd0);
        check("t7_be_zero",   64'(avm_byteenable), 64'd0);
        check("t7_wdata_zero", 64'(avm_writedata), 64'd0);
        hold_wr = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        run_copy(15'h0400, 15'h4000, 13'd2, 1'b0, cyc, err_seen, timeout);
        check("t7_rerun_lat", 64'(cyc), 64'd7);
        check("t7_rerun_err", 64'(err_seen), 64'd0);
        check("t7_rerun_w0",  64'(mem[32'h1000]), 64'(pat(32'h100)));
        check("t7_rerun_w1",  64'(mem[32'h1001]), 64'(pat(32'h101)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
